// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter that shares one pipelined fp_mult among NUM_REQ requesters.
// Each issued op carries its requester id down a tag pipe into a credit-protected result FIFO.
`ifndef FP_MULT_LATENCY
`define FP_MULT_LATENCY 4
`endif

module fp_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MULT_LATENCY = `FP_MULT_LATENCY,
    parameter int FIFO_DEPTH   = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_op0,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_op1,
    output logic                                 mult_enable,
    output logic [DATA_WIDTH-1:0]                mult_op0,
    output logic [DATA_WIDTH-1:0]                mult_op1,
    input  logic [DATA_WIDTH-1:0]                mult_res,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [DATA_WIDTH-1:0]                res_data,
    output logic [ID_W-1:0]                      res_id,
    output logic                                 busy
);

    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FIFO_DEPTH + MULT_LATENCY + 1);

    logic [ID_W-1:0]                         rr_ptr_q, rr_ptr_d;
    logic [MULT_LATENCY-1:0]                 tag_valid_q, tag_valid_d;
    logic [MULT_LATENCY-1:0][ID_W-1:0]       tag_id_q, tag_id_d;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;
    logic [FIFO_DEPTH-1:0][ID_W-1:0]         fifo_id_q, fifo_id_d;
    logic [OW-1:0]                           occ_q, occ_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [CW-1:0]   inflight;
    logic            can_issue;
    logic            issue;
    logic            push;
    logic            pop;
    logic [OW-1:0]   wr_idx;

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Credits come only from registered state; a same-cycle pop does not free a slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MULT_LATENCY; i++) begin
            inflight = inflight + CW'(tag_valid_q[i]);
        end
        can_issue = (inflight + CW'(occ_q)) < CW'(FIFO_DEPTH);
        issue     = grant_found && can_issue && rst;
    end

    always_comb begin
        req_ready   = '0;
        mult_enable = issue;
        mult_op0    = '0;
        mult_op1    = '0;
        rr_ptr_d    = rr_ptr_q;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            mult_op0            = req_op0[grant_id];
            mult_op1            = req_op1[grant_id];
            rr_ptr_d            = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_id_d       = tag_id_q;
        tag_valid_d[0] = issue;
        tag_id_d[0]    = grant_id;
        for (int i = 1; i < MULT_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    assign res_valid = (occ_q != '0);
    assign push      = tag_valid_q[MULT_LATENCY-1];
    assign pop       = res_valid && res_ready;
    assign res_data  = fifo_data_q[0];
    assign res_id    = fifo_id_q[0];
    assign busy      = (|tag_valid_q) || res_valid;

    // Shifting FIFO: entry 0 is always the registered head.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_id_d   = fifo_id_q;
        wr_idx      = pop ? occ_q - 1'b1 : occ_q;
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_data_d[i] = fifo_data_q[i+1];
                fifo_id_d[i]   = fifo_id_q[i+1];
            end
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (OW'(i) == wr_idx)) begin
                fifo_data_d[i] = mult_res;
                fifo_id_d[i]   = tag_id_q[MULT_LATENCY-1];
            end
        end
        occ_d = occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            fifo_data_q <= '0;
            fifo_id_q   <= '0;
            occ_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            fifo_data_q <= fifo_data_d;
            fifo_id_q   <= fifo_id_d;
            occ_q       <= occ_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (occ_q == OW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: stimulus queues expected {data,id}, a monitor pops on each accepted result.
// A behavioural fp_mult stand-in with fixed latency supplies mult_res from a small table of known products.
module tb_fp_mult_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int IDW   = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NREQ-1:0]           req_valid = '0;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][DW-1:0]   req_op0 = '0;
    logic [NREQ-1:0][DW-1:0]   req_op1 = '0;
    logic                      mult_enable;
    logic [DW-1:0]             mult_op0, mult_op1, mult_res;
    logic                      res_valid;
    logic                      res_ready = 1'b0;
    logic [DW-1:0]             res_data;
    logic [IDW-1:0]            res_id;
    logic                      busy;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fp_mult_arbiter #(
        .NUM_REQ(NREQ), .DATA_WIDTH(DW), .MULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .mult_enable(mult_enable), .mult_op0(mult_op0), .mult_op1(mult_op1),
        .mult_res(mult_res),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    // fp_mult stand-in: never reset, so stale products stay on mult_res after a DUT reset.
    function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (a == 32'h7F80_0000 && b == 32'h0000_0000) return 32'h7FC0_0000;
        if (a == 32'hBFC0_0000 && b == 32'h4000_0000) return 32'hC040_0000;
        if (a == 32'h3F80_0000) return b;
        return 32'hDEAD_BEEF ^ a ^ {b[15:0], b[31:16]};
    endfunction

    logic [DW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mult_op0, mult_op1);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_res = mpipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL res_unexpected: actual id=%0d data=%h required=no result", res_id, res_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", res_data, mon_e.data);
                check("res_id", 32'(res_id), 32'(mon_e.id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input int id);
        exp_t e;
        e.data = d;
        e.id   = IDW'(id);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_mult_enable", 32'(mult_enable), 32'h0);
        check("rst_mult_op0", mult_op0, 32'h0);
        check("rst_mult_op1", mult_op1, 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_id", 32'(res_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    // Requesters are held valid with live operands so gating of every output is exercised.
    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_op0[i] = 32'h3F80_0000;
            req_op1[i] = 32'h4100_0000 | i;
        end
        #1;
        check_reset_outputs();
        repeat (2) tick();
        check_reset_outputs();
        exp_q.delete();
        rst       = 1'b1;
        req_valid = '0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k <= budget; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    logic [NREQ-1:0] sp_mask [4] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010};
    int              sp_gnt  [4] = '{1, 3, 1, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // single op from requester 2, exact latency
        res_ready  = 1'b1;
        req_op0[2] = 32'h4000_0000;
        req_op1[2] = 32'h4040_0000;
        req_valid  = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_enable", 32'(mult_enable), 32'h1);
        check("single_op0", mult_op0, 32'h4000_0000);
        check("single_op1", mult_op1, 32'h4040_0000);
        push_exp(32'h40C0_0000, 2);
        tick();
        req_valid = '0;
        check("single_busy", 32'(busy), 32'h1);
        for (int c = 1; c <= LAT; c++) begin
            check("single_early_valid", 32'(res_valid), 32'h0);
            tick();
        end
        check("single_valid_at_lat", 32'(res_valid), 32'h1);
        wait_drain("single_drain", 3);
        tick();
        check("single_idle_busy", 32'(busy), 32'h0);

        // round-robin, all requesters valid
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_op0[i] = 32'h3F80_0000;
            req_op1[i] = 32'h4100_0000 | i;
        end
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
            push_exp(32'h4100_0000 | (k % NREQ), k % NREQ);
            tick();
        end
        req_valid = '0;
        wait_drain("rr_drain", LAT + 1);

        // backpressure: FIFO fills, grants stop, resume one cycle after first pop
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_op0[i] = 32'h3F80_0000;
            req_op1[i] = 32'h4100_0000 | i;
        end
        req_valid = '1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("bp_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
            push_exp(32'h4100_0000 | (k % NREQ), k % NREQ);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            check("bp_no_grant", 32'(req_ready), 32'h0);
            tick();
        end
        check("bp_full_valid", 32'(res_valid), 32'h1);
        check("bp_full_busy", 32'(busy), 32'h1);
        res_ready = 1'b1;
        #1;
        check("bp_pop_cycle_no_grant", 32'(req_ready), 32'h0);
        tick();
        check("bp_resume_grant", 32'(req_ready), 32'h1);
        push_exp(32'h4100_0000, 0);
        tick();
        req_valid = '0;
        wait_drain("bp_drain", 20);

        // sparse requesters 1 and 3, pointer wraps 3 -> 0
        do_reset();
        res_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_op0[i] = 32'h3F80_0000;
                req_op1[i] = 32'h4200_0000 + s;
            end
            req_valid = sp_mask[s];
            #1;
            check("sparse_grant", 32'(req_ready), 32'(1 << sp_gnt[s]));
            push_exp(32'h4200_0000 + s, sp_gnt[s]);
            tick();
        end
        req_valid = '0;
        wait_drain("sparse_drain", LAT + 4);

        // reset while three ops are in flight
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_op0[i] = 32'h3F80_0000;
            req_op1[i] = 32'h4300_0000 | i;
        end
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mid_grant", 32'(req_ready), 32'(1 << k));
            tick();
        end
        req_valid = '0;
        do_reset();
        res_ready = 1'b1;
        for (int k = 0; k < 2 * LAT; k++) begin
            check("mid_no_stale_valid", 32'(res_valid), 32'h0);
            check("mid_no_stale_busy", 32'(busy), 32'h0);
            tick();
        end
        req_op0[3] = 32'h4000_0000;
        req_op1[3] = 32'h4040_0000;
        req_valid  = 4'b1000;
        #1;
        check("mid_new_grant", 32'(req_ready), 32'h8);
        push_exp(32'h40C0_0000, 3);
        tick();
        req_valid = '0;
        wait_drain("mid_drain", LAT + 3);

        // special values from two ids
        do_reset();
        res_ready  = 1'b1;
        req_op0[0] = 32'h7F80_0000;
        req_op1[0] = 32'h0000_0000;
        req_op0[2] = 32'hBFC0_0000;
        req_op1[2] = 32'h4000_0000;
        req_valid  = 4'b0001;
        #1;
        check("spec_grant0", 32'(req_ready), 32'h1);
        push_exp(32'h7FC0_0000, 0);
        tick();
        req_valid = 4'b0100;
        #1;
        check("spec_grant2", 32'(req_ready), 32'h4);
        push_exp(32'hC040_0000, 2);
        tick();
        req_valid = '0;
        wait_drain("spec_drain", LAT + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
